// File: rtl/clock_pkg.sv
// Shared widths, moduli and set-mode state for the clock core and its time setter.
package clock_pkg;

    localparam int SEC_W     = 6;
    localparam int MIN_W     = 6;
    localparam int HOUR_W    = 5;
    localparam int HOURS_MOD = 24;
    localparam int MINS_MOD  = 60;

    typedef enum logic {
        RUN = 1'b0,
        SET = 1'b1
    } set_state_t;

    // Out-of-range values (e.g. hours 24..31) also wrap straight to zero.
    function automatic logic [HOUR_W-1:0] wrap_inc_hours(input logic [HOUR_W-1:0] h);
        return (h >= HOUR_W'(HOURS_MOD - 1)) ? '0 : h + HOUR_W'(1);
    endfunction

    function automatic logic [MIN_W-1:0] wrap_inc_minutes(input logic [MIN_W-1:0] m);
        return (m >= MIN_W'(MINS_MOD - 1)) ? '0 : m + MIN_W'(1);
    endfunction

endpackage

// File: rtl/button_debounce.sv
// Raw push-button to clean one-cycle press pulses, with optional hold-to-repeat.
module button_debounce #(
    parameter bit REPEAT_EN    = 1'b0,
    parameter int HOLD_TICKS   = 50,
    parameter int REPEAT_TICKS = 25
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_tick,
    input  logic i_btn,
    output logic o_press,
    output logic o_repeat
);

    localparam int CNT_MAX = (HOLD_TICKS > REPEAT_TICKS) ? HOLD_TICKS : REPEAT_TICKS;
    localparam int CW      = $clog2(CNT_MAX + 1);

    logic          sync1;
    logic          sync2;
    logic          last_sample;
    logic          level;
    logic          level_next;
    logic          repeating;
    logic [CW-1:0] hold_cnt;
    logic [CW-1:0] cnt_inc;

    // Level only moves when this tick's sample agrees with the previous one.
    always_comb begin
        level_next = (sync2 == last_sample) ? sync2 : level;
        cnt_inc    = hold_cnt + CW'(1);
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            sync1       <= 1'b0;
            sync2       <= 1'b0;
            last_sample <= 1'b0;
            level       <= 1'b0;
            repeating   <= 1'b0;
            hold_cnt    <= '0;
            o_press     <= 1'b0;
            o_repeat    <= 1'b0;
        end else begin
            sync1    <= i_btn;
            sync2    <= sync1;
            o_press  <= 1'b0;
            o_repeat <= 1'b0;
            if (i_tick) begin
                last_sample <= sync2;
                level       <= level_next;
                if (level_next && !level) begin
                    o_press   <= 1'b1;
                    hold_cnt  <= '0;
                    repeating <= 1'b0;
                end else if (level_next && REPEAT_EN) begin
                    // First repeat after HOLD_TICKS, then every REPEAT_TICKS.
                    if (cnt_inc == (repeating ? CW'(REPEAT_TICKS) : CW'(HOLD_TICKS))) begin
                        o_repeat  <= 1'b1;
                        repeating <= 1'b1;
                        hold_cnt  <= '0;
                    end else begin
                        hold_cnt <= cnt_inc;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/sysclk_divider.sv
// Free-running divider: o_overflow pulses for one cycle every SYS_CLK_HZ/OUT_CLK_HZ cycles.
module sysclk_divider #(
    parameter int SYS_CLK_HZ = 50_000_000,
    parameter int OUT_CLK_HZ = 100
) (
    input  logic i_clk,
    input  logic i_reset,
    output logic o_overflow
);

    localparam int DIV = SYS_CLK_HZ / OUT_CLK_HZ;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            cnt <= '0;
        end else if (cnt == CW'(DIV - 1)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign o_overflow = (cnt == CW'(DIV - 1));

endmodule

// File: rtl/clock_time_setter.sv
// Set-mode controller: pauses the clock core, edits shadow hours/minutes from buttons,
// and issues a one-cycle load strobe on exit.
module clock_time_setter
    import clock_pkg::*;
#(
    parameter int SYS_CLK_HZ    = 50_000_000,
    parameter int TICK_HZ       = 100,
    parameter int HOLD_TICKS    = 50,
    parameter int REPEAT_TICKS  = 25,
    parameter int TIMEOUT_TICKS = 3000
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_btn_set,
    input  logic              i_btn_hours,
    input  logic              i_btn_minutes,
    input  logic [SEC_W-1:0]  i_seconds,
    input  logic [MIN_W-1:0]  i_minutes,
    input  logic [HOUR_W-1:0] i_hours,
    output logic              o_clk_en,
    output logic              o_setting,
    output logic              o_load,
    output logic [SEC_W-1:0]  o_seconds,
    output logic [MIN_W-1:0]  o_minutes,
    output logic [HOUR_W-1:0] o_hours
);

    localparam int TO_W = $clog2(TIMEOUT_TICKS + 1);

    logic            tick;
    logic            set_press;
    logic            set_repeat;
    logic            hours_press;
    logic            hours_repeat;
    logic            minutes_press;
    logic            minutes_repeat;
    logic            hours_pulse;
    logic            minutes_pulse;
    logic            any_pulse;
    set_state_t      state;
    logic [TO_W-1:0] idle_ticks;

    sysclk_divider #(
        .SYS_CLK_HZ(SYS_CLK_HZ),
        .OUT_CLK_HZ(TICK_HZ)
    ) u_tick (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .o_overflow(tick)
    );

    button_debounce #(
        .REPEAT_EN   (1'b0),
        .HOLD_TICKS  (HOLD_TICKS),
        .REPEAT_TICKS(REPEAT_TICKS)
    ) u_btn_set (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_tick  (tick),
        .i_btn   (i_btn_set),
        .o_press (set_press),
        .o_repeat(set_repeat)
    );

    button_debounce #(
        .REPEAT_EN   (1'b1),
        .HOLD_TICKS  (HOLD_TICKS),
        .REPEAT_TICKS(REPEAT_TICKS)
    ) u_btn_hours (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_tick  (tick),
        .i_btn   (i_btn_hours),
        .o_press (hours_press),
        .o_repeat(hours_repeat)
    );

    button_debounce #(
        .REPEAT_EN   (1'b1),
        .HOLD_TICKS  (HOLD_TICKS),
        .REPEAT_TICKS(REPEAT_TICKS)
    ) u_btn_minutes (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_tick  (tick),
        .i_btn   (i_btn_minutes),
        .o_press (minutes_press),
        .o_repeat(minutes_repeat)
    );

    always_comb begin
        hours_pulse   = hours_press | hours_repeat;
        minutes_pulse = minutes_press | minutes_repeat;
        any_pulse     = set_press | set_repeat | hours_pulse | minutes_pulse;
    end

    // The o_hours/o_minutes/o_seconds registers are the shadow copy itself.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state      <= RUN;
            o_clk_en   <= 1'b1;
            o_setting  <= 1'b0;
            o_load     <= 1'b0;
            o_seconds  <= '0;
            o_minutes  <= '0;
            o_hours    <= '0;
            idle_ticks <= '0;
        end else begin
            o_load <= 1'b0;
            case (state)
                RUN: begin
                    if (set_press) begin
                        o_hours    <= i_hours;
                        o_minutes  <= i_minutes;
                        o_seconds  <= i_seconds;
                        state      <= SET;
                        o_clk_en   <= 1'b0;
                        o_setting  <= 1'b1;
                        idle_ticks <= '0;
                    end
                end
                SET: begin
                    // A set press wins over any increment arriving in the same cycle.
                    if (set_press) begin
                        o_seconds <= '0;
                        o_load    <= 1'b1;
                        o_clk_en  <= 1'b1;
                        o_setting <= 1'b0;
                        state     <= RUN;
                    end else begin
                        if (hours_pulse) o_hours <= wrap_inc_hours(o_hours);
                        if (minutes_pulse) o_minutes <= wrap_inc_minutes(o_minutes);
                        if (any_pulse) begin
                            idle_ticks <= '0;
                        end else if (tick) begin
                            if (idle_ticks == TO_W'(TIMEOUT_TICKS - 1)) begin
                                state     <= RUN;
                                o_clk_en  <= 1'b1;
                                o_setting <= 1'b0;
                            end else begin
                                idle_ticks <= idle_ticks + TO_W'(1);
                            end
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clock_time_setter.sv
// Bench for clock_time_setter: tick-level button/set-mode reference model plus load scoreboard.
module tb_clock_time_setter;

    localparam int TICK_DIV = 10;
    localparam int HOLD     = 5;
    localparam int REP      = 2;
    localparam int TMO      = 20;
    localparam int LW       = 19;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_set = 1'b0;
    logic       btn_hours = 1'b0;
    logic       btn_minutes = 1'b0;
    logic [5:0] t_sec = '0;
    logic [5:0] t_min = '0;
    logic [4:0] t_hr = '0;
    logic       o_clk_en;
    logic       o_setting;
    logic       o_load;
    logic [5:0] o_seconds;
    logic [5:0] o_minutes;
    logic [4:0] o_hours;

    clock_time_setter #(
        .SYS_CLK_HZ   (1000),
        .TICK_HZ      (100),
        .HOLD_TICKS   (HOLD),
        .REPEAT_TICKS (REP),
        .TIMEOUT_TICKS(TMO)
    ) dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_btn_set    (btn_set),
        .i_btn_hours  (btn_hours),
        .i_btn_minutes(btn_minutes),
        .i_seconds    (t_sec),
        .i_minutes    (t_min),
        .i_hours      (t_hr),
        .o_clk_en     (o_clk_en),
        .o_setting    (o_setting),
        .o_load       (o_load),
        .o_seconds    (o_seconds),
        .o_minutes    (o_minutes),
        .o_hours      (o_hours)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    logic [LW-1:0] exp_q[$];
    logic [LW-1:0] got_q[$];

    // ---------------- reference model ----------------
    // Works on tick samples: a button counts as seen at a tick if it was held at the
    // clock edge two cycles before that tick (two-flop synchronizer).
    int       cyc;
    logic [2:0] samp;
    bit       m_prev[3];
    bit       m_lvl[3];
    int       m_t[3];
    bit       m_set;
    int       m_tc;
    int       sh_h, sh_m, sh_s;

    task automatic model_tick();
        bit press[3];
        bit rep[3];
        bit nl;
        bit sp, hp, mp;
        if (m_set) begin
            m_tc++;
            if (m_tc >= TMO) m_set = 1'b0;
        end
        for (int i = 0; i < 3; i++) begin
            press[i] = 1'b0;
            rep[i]   = 1'b0;
            nl = (samp[i] == m_prev[i]) ? samp[i] : m_lvl[i];
            if (nl && !m_lvl[i]) begin
                press[i] = 1'b1;
                m_t[i]   = 0;
            end else if (nl && i != 0) begin
                m_t[i]++;
                if (m_t[i] >= HOLD && ((m_t[i] - HOLD) % REP) == 0) rep[i] = 1'b1;
            end
            m_lvl[i]  = nl;
            m_prev[i] = samp[i];
        end
        sp = press[0];
        hp = press[1] | rep[1];
        mp = press[2] | rep[2];
        if (!m_set) begin
            if (sp) begin
                sh_h = t_hr; sh_m = t_min; sh_s = t_sec;
                m_set = 1'b1;
                m_tc  = 0;
            end
        end else if (sp) begin
            m_set = 1'b0;
            sh_s  = 0;
            exp_q.push_back({1'b1, 1'b0, 5'(sh_h), 6'(sh_m), 6'd0});
        end else begin
            if (hp) sh_h = (sh_h + 1 >= 24) ? 0 : sh_h + 1;
            if (mp) sh_m = (sh_m + 1 >= 60) ? 0 : sh_m + 1;
            if (hp || mp) m_tc = 0;
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc = 0; samp = '0; m_set = 1'b0; m_tc = 0;
            sh_h = 0; sh_m = 0; sh_s = 0;
            for (int i = 0; i < 3; i++) begin
                m_prev[i] = 1'b0; m_lvl[i] = 1'b0; m_t[i] = 0;
            end
        end else begin
            cyc++;
            if (cyc % TICK_DIV == TICK_DIV - 2) samp = {btn_minutes, btn_hours, btn_set};
            if (cyc % TICK_DIV == 0) model_tick();
        end
    end

    // Observed loads, compared against exp_q inside the tests.
    always @(negedge clk) begin
        if (!rst && o_load) got_q.push_back({o_clk_en, o_setting, o_hours, o_minutes, o_seconds});
    end

    // ---------------- driver tasks ----------------
    task automatic wait_phase(input int p);
        int guard;
        guard = 0;
        @(negedge clk);
        while ((cyc % TICK_DIV) != p && guard < 2 * TICK_DIV) begin
            @(negedge clk);
            guard++;
        end
    endtask

    task automatic press_btn(input bit s, input bit h, input bit m, input int hold);
        wait_phase(5);
        btn_set = s; btn_hours = h; btn_minutes = m;
        repeat (hold) @(negedge clk);
        btn_set = 1'b0; btn_hours = 1'b0; btn_minutes = 1'b0;
        repeat (40) @(negedge clk);
    endtask

    task automatic set_time(input int h, input int m, input int s);
        t_hr = 5'(h); t_min = 6'(m); t_sec = 6'(s);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_vec++; if (o_clk_en !== 1'b1) begin n_err++; $display("FAIL rst_clk_en: got %b want 1", o_clk_en); end
        n_vec++; if (o_setting !== 1'b0) begin n_err++; $display("FAIL rst_setting: got %b want 0", o_setting); end
        n_vec++; if (o_load !== 1'b0) begin n_err++; $display("FAIL rst_load: got %b want 0", o_load); end
        n_vec++; if ({o_hours, o_minutes, o_seconds} !== 17'd0) begin
            n_err++; $display("FAIL rst_time: got %0d:%0d:%0d want 0:0:0", o_hours, o_minutes, o_seconds);
        end
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            repeat (20) @(negedge clk);
            n_vec++;
            if (o_clk_en !== 1'b1 || o_setting !== 1'b0 || o_load !== 1'b0 ||
                {o_hours, o_minutes, o_seconds} !== 17'd0) begin
                n_err++;
                $display("FAIL idle_%0d: got en=%b set=%b load=%b %0d:%0d:%0d want en=1 set=0 load=0 0:0:0",
                         i, o_clk_en, o_setting, o_load, o_hours, o_minutes, o_seconds);
            end
        end
        n_vec++; if (got_q.size() != 0) begin n_err++; $display("FAIL idle_loads: got %0d want 0", got_q.size()); end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_enter_exit();
        logic [LW-1:0] want;
        set_time(12, 34, 56);
        press_btn(1, 0, 0, 40);
        n_vec++; if (o_setting !== 1'b1) begin n_err++; $display("FAIL enter_setting: got %b want 1", o_setting); end
        n_vec++; if (o_clk_en !== 1'b0) begin n_err++; $display("FAIL enter_clk_en: got %b want 0", o_clk_en); end
        n_vec++; if (o_hours !== 5'd12 || o_minutes !== 6'd34 || o_seconds !== 6'd56) begin
            n_err++; $display("FAIL enter_shadow: got %0d:%0d:%0d want 12:34:56", o_hours, o_minutes, o_seconds);
        end
        press_btn(1, 0, 0, 40);
        want = {1'b1, 1'b0, 5'd12, 6'd34, 6'd0};
        n_vec++;
        if (got_q.size() != 1) begin
            n_err++; $display("FAIL exit_load_count: got %0d want 1", got_q.size());
        end else if (got_q[0] !== want) begin
            n_err++; $display("FAIL exit_load: got %h want %h", got_q[0], want);
        end
        n_vec++; if (exp_q.size() != 1 || exp_q[0] !== want) begin
            n_err++; $display("FAIL exit_model: got %0d entries want 1 matching %h", exp_q.size(), want);
        end
        n_vec++; if (o_setting !== 1'b0 || o_clk_en !== 1'b1) begin
            n_err++; $display("FAIL exit_state: got set=%b en=%b want set=0 en=1", o_setting, o_clk_en);
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_wrap();
        logic [LW-1:0] want;
        set_time(23, 59, 10);
        press_btn(1, 0, 0, 40);
        press_btn(0, 1, 0, 40);
        press_btn(0, 0, 1, 40);
        press_btn(1, 0, 0, 40);
        want = {1'b1, 1'b0, 5'd0, 6'd0, 6'd0};
        n_vec++;
        if (got_q.size() != 1) begin
            n_err++; $display("FAIL wrap_load_count: got %0d want 1", got_q.size());
        end else if (got_q[0] !== want) begin
            n_err++; $display("FAIL wrap_load: got %h want %h", got_q[0], want);
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_hold_repeat();
        int want_min;
        // 15 held ticks: press 2 ticks in, repeats from 5 ticks later, every 2 ticks.
        want_min = 10 + 1 + ((15 - 2 - 5) / 2 + 1);
        set_time(5, 10, 0);
        press_btn(1, 0, 0, 40);
        press_btn(0, 0, 1, 150);
        n_vec++; if (o_minutes !== 6'(want_min)) begin
            n_err++; $display("FAIL hold_minutes: got %0d want %0d", o_minutes, want_min);
        end
        n_vec++; if (o_minutes !== 6'(sh_m)) begin
            n_err++; $display("FAIL hold_model: got %0d want %0d", o_minutes, sh_m);
        end
        wait_phase(7);
        for (int j = 0; j < 10; j++) begin
            btn_minutes = (j % 2 == 0);
            repeat (3) @(negedge clk);
        end
        btn_minutes = 1'b0;
        repeat (20) @(negedge clk);
        n_vec++; if (o_minutes !== 6'(want_min) || o_minutes !== 6'(sh_m)) begin
            n_err++; $display("FAIL bounce_minutes: got %0d want %0d", o_minutes, want_min);
        end
        n_vec++; if (o_setting !== 1'b1) begin n_err++; $display("FAIL bounce_setting: got %b want 1", o_setting); end
        press_btn(1, 0, 0, 40);
        n_vec++;
        if (got_q.size() != 1) begin
            n_err++; $display("FAIL hold_load_count: got %0d want 1", got_q.size());
        end else if (got_q[0] !== {1'b1, 1'b0, 5'd5, 6'(want_min), 6'd0}) begin
            n_err++; $display("FAIL hold_load: got %h want min %0d", got_q[0], want_min);
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_timeout();
        set_time(7, 8, 9);
        press_btn(1, 0, 0, 40);
        repeat (100) @(negedge clk);
        n_vec++; if (o_setting !== 1'b1 || o_setting !== m_set) begin
            n_err++; $display("FAIL timeout_early: got set=%b want 1", o_setting);
        end
        repeat (150) @(negedge clk);
        n_vec++; if (o_setting !== 1'b0 || o_clk_en !== 1'b1) begin
            n_err++; $display("FAIL timeout_exit: got set=%b en=%b want set=0 en=1", o_setting, o_clk_en);
        end
        n_vec++; if (got_q.size() != 0 || exp_q.size() != 0) begin
            n_err++; $display("FAIL timeout_load: got %0d loads want 0", got_q.size());
        end
        n_vec++; if (o_hours !== 5'd7 || o_minutes !== 6'd8) begin
            n_err++; $display("FAIL timeout_shadow: got %0d:%0d want 7:8", o_hours, o_minutes);
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_run_ignore();
        logic [4:0] h0;
        logic [5:0] m0;
        h0 = 5'(sh_h); m0 = 6'(sh_m);
        set_time(3, 4, 5);
        press_btn(0, 1, 0, 40);
        press_btn(0, 0, 1, 40);
        n_vec++; if (o_hours !== h0 || o_minutes !== m0) begin
            n_err++; $display("FAIL run_ignore_shadow: got %0d:%0d want %0d:%0d", o_hours, o_minutes, h0, m0);
        end
        n_vec++; if (o_setting !== 1'b0 || got_q.size() != 0) begin
            n_err++; $display("FAIL run_ignore_state: got set=%b loads=%0d want 0 0", o_setting, got_q.size());
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_set_wins();
        set_time(10, 20, 30);
        press_btn(1, 0, 0, 40);
        press_btn(1, 1, 0, 40);
        n_vec++;
        if (got_q.size() != 1) begin
            n_err++; $display("FAIL set_wins_count: got %0d want 1", got_q.size());
        end else if (got_q[0] !== {1'b1, 1'b0, 5'd10, 6'd20, 6'd0}) begin
            n_err++; $display("FAIL set_wins_load: got %h want 10:20:00", got_q[0]);
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_random();
        int ops;
        int kind;
        for (int it = 0; it < 8; it++) begin
            set_time($urandom_range(31, 0), $urandom_range(63, 0), $urandom_range(59, 0));
            press_btn(1, 0, 0, $urandom_range(60, 25));
            ops = $urandom_range(5, 1);
            for (int k = 0; k < ops; k++) begin
                kind = $urandom_range(2, 0);
                press_btn(0, kind != 1, kind != 0, $urandom_range(120, 20));
            end
            press_btn(1, 0, 0, $urandom_range(60, 25));
            n_vec++;
            if (got_q.size() != exp_q.size()) begin
                n_err++; $display("FAIL rand_%0d_count: got %0d want %0d", it, got_q.size(), exp_q.size());
            end else begin
                foreach (got_q[i]) begin
                    n_vec++;
                    if (got_q[i] !== exp_q[i]) begin
                        n_err++; $display("FAIL rand_%0d_load: got %h want %h", it, got_q[i], exp_q[i]);
                    end
                end
            end
            got_q.delete(); exp_q.delete();
        end
    endtask

    task automatic test_reset_mid_set();
        set_time(9, 41, 17);
        press_btn(1, 0, 0, 40);
        n_vec++; if (o_setting !== 1'b1) begin n_err++; $display("FAIL mid_enter: got %b want 1", o_setting); end
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_vec++;
        if (o_clk_en !== 1'b1 || o_setting !== 1'b0 || o_load !== 1'b0 ||
            {o_hours, o_minutes, o_seconds} !== 17'd0) begin
            n_err++;
            $display("FAIL mid_reset: got en=%b set=%b load=%b %0d:%0d:%0d want en=1 set=0 load=0 0:0:0",
                     o_clk_en, o_setting, o_load, o_hours, o_minutes, o_seconds);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (50) @(negedge clk);
        n_vec++; if (got_q.size() != 0 || o_setting !== 1'b0) begin
            n_err++; $display("FAIL mid_after: got loads=%0d set=%b want 0 0", got_q.size(), o_setting);
        end
        got_q.delete(); exp_q.delete();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_enter_exit();
        test_wrap();
        test_hold_repeat();
        test_timeout();
        test_run_ignore();
        test_set_wins();
        test_random();
        test_reset_mid_set();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        n_err++;
        $display("FAIL watchdog: time limit reached before end of tests");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/clock_time_setter.md
Name: clock_time_setter

Overview:
- Writer-side counterpart to the free-running seconds/minutes/hours clock core.
- Takes three raw push-buttons (set, hours, minutes) and runs a set-mode FSM. While in set mode it pauses the clock core and edits shadow copies of the time.
- On exit it emits a one-cycle load strobe with the new time.
- Sits between the board button pins and the clock core's load/enable inputs.

Parameters:
- SYS_CLK_HZ, 50_000_000, system clock frequency.
- TICK_HZ, 100, debounce/repeat sample tick rate.
- HOLD_TICKS, 50, ticks a held button must stay down before auto-repeat starts.
- REPEAT_TICKS, 25, ticks between auto-repeat increments.
- TIMEOUT_TICKS, 3000, idle ticks in set mode before abort without load.

Ports:
- i_clk  input  1  system clock
- i_reset  input  1  asynchronous active-high reset
- i_btn_set  input  1  raw set button, active high, asynchronous to i_clk
- i_btn_hours  input  1  raw hours-increment button
- i_btn_minutes  input  1  raw minutes-increment button
- i_seconds  input  6  current seconds from clock core
- i_minutes  input  6  current minutes from clock core
- i_hours  input  5  current hours from clock core
- o_clk_en  output  1  enable to clock core counting; 0 while setting
- o_setting  output  1  high while in set mode (display blink hint)
- o_load  output  1  one-cycle strobe: clock core loads o_seconds/o_minutes/o_hours
- o_seconds  output  6  time to load / shadow seconds
- o_minutes  output  6  shadow minutes
- o_hours  output  5  shadow hours

Behaviour:
- Interface: one clock i_clk; reset i_reset is asynchronous, active-high.
- Reset values: o_clk_en=1, o_setting=0, o_load=0, o_seconds=o_minutes=o_hours=0, FSM=RUN, all debounce state cleared (buttons considered released).
- Tick: single-cycle pulse every SYS_CLK_HZ/TICK_HZ cycles, free-running from reset.
- Button path, per button:
  - 2-flop synchronizer.
  - Debounced level changes only after 2 consecutive tick samples agree.
  - press pulse = 1 cycle on the debounced 0->1 edge.
  - Hours/minutes only: while debounced high, after HOLD_TICKS ticks emit a repeat pulse, then one every REPEAT_TICKS ticks.
  - The set button never repeats.
- FSM states RUN, SET.
- RUN:
  - o_clk_en=1.
  - Hours/minutes pulses are ignored.
  - On a set press: shadow <= {i_hours, i_minutes, i_seconds} sampled that cycle; next state SET; o_clk_en=0 and o_setting=1 from the next cycle.
- SET:
  - Hours pulse: shadow hours +1, 23 wraps to 0.
  - Minutes pulse: shadow minutes +1, 59 wraps to 0. No carry into hours.
  - Both pulses in the same cycle: both increment.
  - Set press: o_load=1 for exactly the next cycle with o_hours/o_minutes = shadow, o_seconds=0; state returns to RUN. o_clk_en=1 in the same cycle as o_load, so the core counts from the loaded value.
  - Set press coincident with an increment: set wins, increment discarded.
  - Timeout: counter cleared by any press/repeat pulse, increments per tick. At TIMEOUT_TICKS → RUN with no o_load; clock core resumes from its paused value.
- o_seconds/o_minutes/o_hours mirror the shadow registers at all times. Their value is only meaningful when o_load=1.
- Reset mid-SET: immediate return to RUN values, no o_load.
- Input out-of-range (hours>23 or minutes>59 captured): first increment wraps to 0.

Decomposition:
- Shared package (clock_pkg): SEC_W=6, MIN_W=6, HOUR_W=5, HOURS_MOD=24, MINS_MOD=60, FSM state enum {RUN, SET}.
- Tick: reuse the existing sysclk_divider (OUT_CLK_HZ=TICK_HZ, overflow output).
- Sub-module: button_debounce (synchronizer, 2-sample debounce, press pulse, optional hold/repeat via REPEAT_EN parameter). Instantiated 3 times.

Test Plan:
All scenarios use SYS_CLK_HZ=1000, TICK_HZ=100 (tick every 10 cycles), HOLD_TICKS=5, REPEAT_TICKS=2, TIMEOUT_TICKS=20.
- Reset then idle 200 cycles -> o_clk_en=1, o_setting=0, o_load never asserts, outputs 0.
- i_time=12:34:56, press set (held 40 cycles) -> o_setting=1, o_clk_en=0, shadow 12:34:56. Press set again -> single o_load pulse with 12:34:00, o_clk_en=1 the same cycle, o_setting=0.
- In SET with shadow 23:59, press hours once and minutes once -> on the next set press, o_load carries 00:00:00 (wraps, no carry).
- In SET with shadow 05:10, hold minutes 150 cycles -> exactly 1 press + floor((15-2-5)/2)+1 repeats, counted against the bench's tick model. Bouncing input toggling every 3 cycles for 30 cycles -> no increment.
- In SET with no presses for 20 ticks -> back to RUN, o_clk_en=1, o_load stays 0. Assert i_reset mid-SET -> all outputs at reset values asynchronously.
- In RUN, press hours/minutes -> no o_load, shadow unchanged. In SET, set and hours debounced-press in the same cycle -> load occurs, hours not incremented.
